// File: rtl/scrambler_pkg.sv
// Shared constants and the single-step LFSR function used by the
// transmit scrambler and the receive-side descrambler.
package scrambler_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_LFSR_W = 7;
    localparam logic [DEF_LFSR_W-1:0] DEF_TAPS = 7'h60;
    localparam logic [DEF_LFSR_W-1:0] DEF_SEED = 7'h7F;

    typedef struct packed {
        logic [DEF_LFSR_W-1:0] state;
        logic                  k;
    } lfsr_step_t;

    // Fibonacci step: the feedback bit is both the keystream bit and the new LSB.
    function automatic lfsr_step_t lfsr_step(
        input logic [DEF_LFSR_W-1:0] state,
        input logic [DEF_LFSR_W-1:0] taps
    );
        lfsr_step_t r;
        r.k     = ^(state & taps);
        r.state = {state[DEF_LFSR_W-2:0], r.k};
        return r;
    endfunction

endpackage

// File: rtl/frame_scrambler_tx_lfsr_multistep.sv
// Combinational DATA_W-step LFSR advance producing one keystream word.
module lfsr_multistep
    import scrambler_pkg::*;
#(
    parameter int unsigned           DATA_W = DEF_DATA_W,
    parameter logic [DEF_LFSR_W-1:0] TAPS   = DEF_TAPS
) (
    input  logic [DEF_LFSR_W-1:0] start,
    output logic [DATA_W-1:0]     keystream,
    output logic [DEF_LFSR_W-1:0] end_state
);

    logic [DEF_LFSR_W-1:0] s;
    lfsr_step_t            r;

    // Bit i of the word comes from step i+1, so the LSB is generated first.
    always_comb begin
        s         = start;
        r         = '0;
        keystream = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            r            = lfsr_step(s, TAPS);
            keystream[i] = r.k;
            s            = r.state;
        end
        end_state = s;
    end

endmodule

// File: rtl/frame_scrambler_tx.sv
// Transmit additive scrambler: reseeds on start-of-frame, XORs each beat
// with an LFSR keystream, one registered valid/ready output stage.
module frame_scrambler_tx
    import scrambler_pkg::*;
#(
    parameter int unsigned           DATA_W = DEF_DATA_W,
    parameter int unsigned           LFSR_W = DEF_LFSR_W,
    parameter logic [DEF_LFSR_W-1:0] TAPS   = DEF_TAPS,
    parameter logic [DEF_LFSR_W-1:0] SEED   = DEF_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sof,
    input  logic                  in_bypass,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_sof,
    output logic [DEF_LFSR_W-1:0] lfsr_state
);

    if (SEED == '0) begin : g_bad_seed
        $error("frame_scrambler_tx: SEED must be nonzero");
    end
    if (LFSR_W != DEF_LFSR_W) begin : g_bad_width
        $error("frame_scrambler_tx: LFSR_W must match scrambler_pkg");
    end

    logic                  accept;
    logic [DEF_LFSR_W-1:0] start_state;
    logic [DEF_LFSR_W-1:0] next_state;
    logic [DATA_W-1:0]     keystream;

    assign in_ready    = ~out_valid | out_ready;
    assign accept      = in_valid & in_ready;
    assign start_state = in_sof ? SEED : lfsr_state;

    lfsr_multistep #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_step (
        .start     (start_state),
        .keystream (keystream),
        .end_state (next_state)
    );

    // The LFSR advances on every accepted beat, bypassed or not,
    // so the receiver stays in step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            lfsr_state <= SEED;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_bypass ? in_data : (in_data ^ keystream);
            out_sof    <= in_sof;
            lfsr_state <= next_state;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_scrambler_tx.sv
// Self-checking bench for frame_scrambler_tx: keystream modelled as a
// bit recurrence over a history queue, plus an independent loopback descrambler.
module tb_frame_scrambler_tx;

    localparam int DW = 8;
    localparam int LW = 7;
    localparam logic [LW-1:0] TAPS = 7'h60;
    localparam logic [LW-1:0] SEED = 7'h7F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_bypass = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic [LW-1:0] lfsr_state;

    int checks = 0;
    int failures = 0;

    frame_scrambler_tx dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_bypass  (in_bypass),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    // Keystream as a sequence: a[n] = XOR of a[n-1-j] over tap bits j.
    bit tx_hist[$];
    bit rx_hist[$];

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sof;

    bit            capture = 0;
    logic [DW+1:0] plain_q[$];
    logic [DW:0]   cap_q[$];

    task automatic reseed(input int which);
        for (int j = LW - 1; j >= 0; j--) begin
            if (which == 0) tx_hist.push_back(SEED[j]);
            else rx_hist.push_back(SEED[j]);
        end
    endtask

    task automatic ks_word(input int which, output logic [DW-1:0] w);
        bit fb;
        int n;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            fb = 0;
            n = (which == 0) ? tx_hist.size() : rx_hist.size();
            for (int j = 0; j < LW; j++)
                if (TAPS[j])
                    fb ^= (which == 0) ? tx_hist[n-1-j] : rx_hist[n-1-j];
            if (which == 0) begin
                tx_hist.push_back(fb);
                if (tx_hist.size() > 64) void'(tx_hist.pop_front());
            end else begin
                rx_hist.push_back(fb);
                if (rx_hist.size() > 64) void'(rx_hist.pop_front());
            end
            w[i] = fb;
        end
    endtask

    function automatic logic [LW-1:0] m_state();
        logic [LW-1:0] s;
        int n = tx_hist.size();
        for (int j = 0; j < LW; j++) s[j] = tx_hist[n-1-j];
        return s;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data = '0;
        m_sof = 1'b0;
        tx_hist.delete();
        reseed(0);
    endtask

    // Called at a falling edge; drives one cycle and checks the result.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d,
                               input logic s, input logic b, input logic r);
        logic exp_ready, acc;
        logic [DW-1:0] ks;
        in_valid = v;
        in_data = d;
        in_sof = s;
        in_bypass = b;
        out_ready = r;
        #1;
        exp_ready = !m_valid || r;
        acc = v && exp_ready;
        checks++;
        if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_ready);
        end
        if (capture && out_valid && r) cap_q.push_back({out_sof, out_data});
        if (capture && acc) plain_q.push_back({s, b, d});
        @(posedge clk);
        if (acc) begin
            if (s) begin
                tx_hist.delete();
                reseed(0);
            end
            ks_word(0, ks);
            m_data = b ? d : (d ^ ks);
            m_sof = s;
            m_valid = 1'b1;
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== m_valid || out_data !== m_data || out_sof !== m_sof) begin
            failures++;
            $display("FAIL out_beat: got v=%b d=%h s=%b want v=%b d=%h s=%b",
                     out_valid, out_data, out_sof, m_valid, m_data, m_sof);
        end
        checks++;
        if (lfsr_state !== m_state()) begin
            failures++;
            $display("FAIL lfsr_state: got %h want %h", lfsr_state, m_state());
        end
        checks++;
        if (lfsr_state === '0) begin
            failures++;
            $display("FAIL lfsr_zero: got %h want nonzero", lfsr_state);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sof !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got v=%b d=%h s=%b want 0 00 0",
                     out_valid, out_data, out_sof);
        end
        checks++;
        if (lfsr_state !== SEED || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got lfsr=%h rdy=%b want 7f 1",
                     lfsr_state, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        drive_cycle(1, 8'h00, 1, 0, 1);
        checks++;
        if (out_data !== 8'h40 || out_sof !== 1'b1 || lfsr_state !== 7'h02) begin
            failures++;
            $display("FAIL vec_sof: got d=%h s=%b lfsr=%h want 40 1 02",
                     out_data, out_sof, lfsr_state);
        end
        drive_cycle(1, 8'h00, 0, 0, 1);
        checks++;
        if (out_data !== 8'h30 || out_sof !== 1'b0 || lfsr_state !== 7'h0C) begin
            failures++;
            $display("FAIL vec_second: got d=%h s=%b lfsr=%h want 30 0 0c",
                     out_data, out_sof, lfsr_state);
        end
        drive_cycle(1, 8'hFF, 0, 1, 1);
        checks++;
        if (out_data !== 8'hFF || lfsr_state === 7'h0C) begin
            failures++;
            $display("FAIL vec_bypass: got d=%h lfsr=%h want ff, lfsr advanced",
                     out_data, lfsr_state);
        end
        drive_cycle(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held_d;
        logic [LW-1:0] held_s;
        drive_cycle(1, 8'($urandom), 0, 0, 0);
        held_d = out_data;
        held_s = lfsr_state;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 8'($urandom), 0, 0, 0);
            checks++;
            if (in_ready !== 1'b0 || out_data !== held_d || lfsr_state !== held_s) begin
                failures++;
                $display("FAIL backpressure_hold: got rdy=%b d=%h lfsr=%h want 0 %h %h",
                         in_ready, out_data, lfsr_state, held_d, held_s);
            end
        end
        for (int i = 0; i < 6; i++)
            drive_cycle(1, 8'($urandom), 0, 1'($urandom), 1);
        drive_cycle(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_mid_sof();
        drive_cycle(1, 8'($urandom), 1, 0, 1);
        for (int i = 0; i < 3; i++)
            drive_cycle(1, 8'($urandom), 0, 0, 1);
        drive_cycle(1, 8'h00, 1, 0, 1);
        checks++;
        if (out_data !== 8'h40) begin
            failures++;
            $display("FAIL mid_sof: got %h want 40", out_data);
        end
        drive_cycle(1, 8'h00, 1, 0, 1);
        checks++;
        if (out_data !== 8'h40 || lfsr_state !== 7'h02) begin
            failures++;
            $display("FAIL consecutive_sof: got d=%h lfsr=%h want 40 02",
                     out_data, lfsr_state);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 8'h5A, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || lfsr_state !== SEED || out_data !== '0) begin
            failures++;
            $display("FAIL reset_async: got v=%b lfsr=%h d=%h want 0 7f 00",
                     out_valid, lfsr_state, out_data);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive_cycle(1, 8'h00, 1, 0, 1);
        checks++;
        if (out_data !== 8'h40) begin
            failures++;
            $display("FAIL reset_restart: got %h want 40", out_data);
        end
        drive_cycle(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_loopback();
        logic [DW-1:0] ks, rec;
        logic [DW+1:0] p;
        logic [DW:0]   c;
        plain_q.delete();
        cap_q.delete();
        capture = 1;
        for (int i = 0; i < 256; i++) begin
            drive_cycle(1, 8'($urandom), (i == 0) || ($urandom_range(31) == 0),
                        ($urandom_range(15) == 0), 1);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_rate: beat %0d in_ready=%b want 1", i, in_ready);
            end
        end
        drive_cycle(0, 8'h00, 0, 0, 1);
        capture = 0;
        checks++;
        if (cap_q.size() != 256 || plain_q.size() != 256) begin
            failures++;
            $display("FAIL loop_count: got out=%0d in=%0d want 256",
                     cap_q.size(), plain_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < plain_q.size(); i++) begin
            p = plain_q[i];
            c = cap_q[i];
            if (c[DW]) begin
                rx_hist.delete();
                reseed(1);
            end
            ks_word(1, ks);
            rec = p[DW] ? c[DW-1:0] : (c[DW-1:0] ^ ks);
            checks++;
            if (rec !== p[DW-1:0] || c[DW] !== p[DW+1]) begin
                failures++;
                $display("FAIL loopback: beat %0d got %h sof=%b want %h sof=%b",
                         i, rec, c[DW], p[DW-1:0], p[DW+1]);
            end
        end
    endtask

    initial begin
        model_reset();
        rx_hist.delete();
        reseed(1);
        test_reset();
        test_vectors();
        test_backpressure();
        test_mid_sof();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
